lisnoc_router_input_vc: RTL and testbench
=========================================

// Module: lisnoc_router_input_vc
// PURPOSE
//  Router input port: counterpart of the router output port on the same link. Takes link flits
//  per virtual channel and buffers each VC in its own FIFO. Decodes the destination in the
//  header flit via a lookup table, then drives a one-hot switch request towards the
//  destination output port. The route is held until the LAST flit has been read by the switch.
// PARAMETERS
//  flit_data_width  32    payload bits per flit
//  flit_type_width  2     type bits; flit = {type, data}; HEADER=2'b01 PAYLOAD=2'b00 LAST=2'b10 SINGLE=2'b11
//  ph_dest_width    5     destination field = data[flit_data_width-1 -: ph_dest_width]
//  vchannels        1     number of virtual channels
//  ports            5     number of switch output ports
//  fifo_length      4     per-VC input FIFO depth, >=2
//  destinations     32    number of valid destinations
//  lookup           {destinations{5'b00001}}  route table; bit dest*ports+p set => dest exits port p; each entry one-hot or zero
// PORTS
//  clk             in   1                     clock
//  rst             in   1                     asynchronous, active-low reset
//  link_flit       in   flit_width            incoming flit (flit_width = data+type)
//  link_valid      in   vchannels             flit valid for VC v
//  link_ready      out  vchannels             VC v FIFO can accept a flit
//  switch_request  out  ports*vchannels       bit v*ports+p: VC v head flit requests output port p
//  switch_flit     out  flit_width*vchannels  head flit of VC v at [(v+1)*flit_width-1 : v*flit_width]
//  switch_read     in   ports*vchannels       bit v*ports+p: output port p consumed VC v head flit this cycle
//  error_o         out  vchannels             1-cycle pulse on a protocol/route error in VC v
// BEHAVIOUR
//  Reset (rst low, async): all FIFOs empty, all states IDLE.
//   Outputs during reset: link_ready=0, switch_request=0, error_o=0, switch_flit=0.
//   After release, link_ready=all ones. A reset mid-packet discards all buffered flits.
//  Push: a flit is written to FIFO v when link_valid[v] & link_ready[v].
//   link_ready[v] = !full[v]; it has no combinational path from switch_read.
//   A full FIFO popped in the same cycle still shows link_ready=0 that cycle.
//  Latency: a flit pushed in cycle N is at the FIFO head with its switch_request asserted in N+1.
//  Pop: head of VC v is popped when |(switch_read[v*ports+:ports] & switch_request[v*ports+:ports]).
//   switch_read bits on non-requested ports are ignored.
//   Throughput: 1 flit/cycle/VC with push and pop in the same cycle.
//  Per-VC FSM, states IDLE, ACTIVE, DROP. route_q[ports] is held with the FSM.
//   IDLE, head HEADER/SINGLE: dest = destination field; route = lookup entry if dest<destinations, else 0.
//    route!=0: switch_request = route (combinational on head; FIFO output is registered).
//      On pop of HEADER: route_q<=route, go to ACTIVE. On pop of SINGLE: stay IDLE.
//    route==0: pulse error_o[v], pop without a request.
//      HEADER goes to DROP; SINGLE stays IDLE.
//   IDLE, head PAYLOAD/LAST: pulse error_o[v], pop and discard the flit, stay IDLE.
//   ACTIVE: switch_request = route_q while the head is valid.
//    Popping LAST returns to IDLE.
//    A HEADER/SINGLE at the head is forwarded as payload and pulses error_o[v].
//   DROP: pop one flit per cycle without a request. Popping LAST returns to IDLE.
//  Empty FIFO: switch_request for that VC = 0. switch_flit = head content (don't-care when empty).
//  VCs are fully independent; there is no cross-VC arbitration in this block.
// TESTING
//  1. VC0, lookup dest3 -> port2; send HEADER(dest3), PAYLOAD, LAST.
//     Expect switch_request[2] one cycle after each push. Hold switch_read=0 for 3 cycles:
//     request and flit stay stable, no pop. Then read each cycle: 3 pops, FSM back to IDLE.
//  2. fifo_length=4, switch_read=0, push 5 flits.
//     link_ready drops after the 4th push and the 5th is not taken.
//     One read raises link_ready the next cycle.
//  3. SINGLE(dest0) -> port0.
//     One-cycle request, pop on read, stays IDLE, next HEADER decoded immediately.
//  4. HEADER with dest=33 (>=destinations), PAYLOAD, LAST.
//     error_o[v]=1 for 1 cycle, no switch_request ever, all 3 flits drained in DROP.
//  5. PAYLOAD at head in IDLE -> error_o pulse, flit discarded.
//     rst pulled low mid-packet -> link_ready=0, request=0 immediately (async).
//     After release, FIFO is empty.
//  6. vchannels=2: interleave VC0 (port1) and VC1 (port4) packets, stalling VC0 reads.
//     VC1 flows at 1 flit/cycle, unaffected.

Source files
------------

// File: rtl/lisnoc_router_input_vc.sv
// lisnoc_router_input_vc: per-VC input FIFOs with header route lookup driving one-hot switch requests.
module lisnoc_router_input_vc #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int vchannels       = 1,
  parameter int ports           = 5,
  parameter int fifo_length     = 4,
  parameter int destinations    = 32,
  parameter logic [destinations*ports-1:0] lookup = {destinations{5'b00001}}
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [flit_data_width+flit_type_width-1:0]           link_flit,
  input  logic [vchannels-1:0]                                link_valid,
  output logic [vchannels-1:0]                                link_ready,
  output logic [ports*vchannels-1:0]                          switch_request,
  output logic [(flit_data_width+flit_type_width)*vchannels-1:0] switch_flit,
  input  logic [ports*vchannels-1:0]                          switch_read,
  output logic [vchannels-1:0]                                error_o
);
  localparam int FW = flit_data_width + flit_type_width;
  localparam int PW = $clog2(fifo_length);
  localparam int CW = $clog2(fifo_length + 1);
  localparam logic [flit_type_width-1:0] HEADER = flit_type_width'(2'b01);
  localparam logic [flit_type_width-1:0] LAST   = flit_type_width'(2'b10);
  localparam logic [flit_type_width-1:0] SINGLE = flit_type_width'(2'b11);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(fifo_length - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    logic [FW-1:0]              mem_q [fifo_length];
    logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]              cnt_q;
    state_t                     state_q, state_d;
    logic [ports-1:0]           route_q, route_d, route, req, rd;
    logic [FW-1:0]              head;
    logic [flit_type_width-1:0] ftype;
    logic [ph_dest_width-1:0]   dest;
    logic                       valid, full, push, pop, err, is_hdr, is_last;

    assign head    = mem_q[rd_ptr_q];
    assign valid   = cnt_q != '0;
    assign full    = cnt_q == CW'(fifo_length);
    assign push    = link_valid[v] & link_ready[v];
    assign rd      = switch_read[v*ports +: ports];
    assign ftype   = head[FW-1 -: flit_type_width];
    assign dest    = head[flit_data_width-1 -: ph_dest_width];
    assign is_hdr  = (ftype == HEADER) | (ftype == SINGLE);
    assign is_last = ftype == LAST;
    // destinations beyond the table have no route and are dropped
    assign route   = (int'(dest) < destinations) ? lookup[int'(dest)*ports +: ports] : '0;

    assign link_ready[v]                = rst & ~full;
    assign switch_request[v*ports +: ports] = req;
    assign switch_flit[v*FW +: FW]      = head;
    assign error_o[v]                   = err;

    always_comb begin
      state_d = state_q;
      route_d = route_q;
      req     = '0;
      pop     = 1'b0;
      err     = 1'b0;
      if (valid)
        case (state_q)
          IDLE:
            if (is_hdr && route != '0) begin
              req = route;
              pop = |(rd & route);
              if (pop && ftype == HEADER) begin
                route_d = route;
                state_d = ACTIVE;
              end
            end else begin
              err = 1'b1;
              pop = 1'b1;
              state_d = (ftype == HEADER) ? DROP : IDLE;
            end
          ACTIVE: begin
            req = route_q;
            pop = |(rd & route_q);
            err = pop & is_hdr;
            state_d = (pop && is_last) ? IDLE : ACTIVE;
          end
          default: begin
            pop = 1'b1;
            state_d = is_last ? IDLE : DROP;
          end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= IDLE;
        route_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        mem_q    <= '{default: '0};
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        if (push) begin
          mem_q[wr_ptr_q] <= link_flit;
          wr_ptr_q        <= nxt(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= nxt(rd_ptr_q);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_lisnoc_router_input_vc.sv
// tb_lisnoc_router_input_vc: scoreboard bench for the router input VC block (2 VCs, 5 ports).
module tb_lisnoc_router_input_vc;
  localparam int FW = 34;
  localparam int NV = 2;
  localparam int NP = 5;
  localparam logic [1:0] HDR = 2'b01, PAY = 2'b00, LST = 2'b10, SGL = 2'b11;

  function automatic logic [159:0] mk_lut();
    logic [159:0] l;
    l = '0;
    for (int d = 0; d < 32; d++) l[d*5 +: 5] = 5'b00001;
    l[1*5 +: 5] = 5'b00010;
    l[3*5 +: 5] = 5'b00100;
    l[4*5 +: 5] = 5'b10000;
    l[5*5 +: 5] = 5'b00000;
    return l;
  endfunction
  localparam logic [159:0] LUT = mk_lut();

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [FW-1:0]    link_flit = '0;
  logic [NV-1:0]    link_valid = '0;
  logic [NV-1:0]    link_ready, error_o;
  logic [NP*NV-1:0] switch_request;
  logic [NP*NV-1:0] switch_read = '0;
  logic [FW*NV-1:0] switch_flit;

  int n_chk = 0;
  int n_err = 0;
  int err_cnt [NV];
  logic [38:0] sb0[$], sb1[$];
  logic [4:0]  mr;
  logic [38:0] me;
  logic [33:0] h, s;
  int e0, e1;

  always #5 clk = ~clk;

  lisnoc_router_input_vc #(
    .flit_data_width(32), .flit_type_width(2), .ph_dest_width(6), .vchannels(NV),
    .ports(NP), .fifo_length(4), .destinations(32), .lookup(LUT)
  ) dut (
    .clk(clk), .rst(rst), .link_flit(link_flit), .link_valid(link_valid),
    .link_ready(link_ready), .switch_request(switch_request), .switch_flit(switch_flit),
    .switch_read(switch_read), .error_o(error_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] fl(input logic [1:0] t, input logic [5:0] d, input logic [25:0] x);
    return {t, d, x};
  endfunction

  function automatic int sb_size(input int v);
    return (v == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input logic [33:0] f, input logic [4:0] port);
    link_flit = f;
    link_valid = '0;
    link_valid[v] = 1'b1;
    if (port != '0) begin
      if (v == 0) sb0.push_back({port, f});
      else sb1.push_back({port, f});
    end
    tick;
    link_valid = '0;
  endtask

  task automatic drain(input int v, input logic [4:0] port);
    switch_read[v*NP +: NP] = port;
    for (int i = 0; i < 20 && sb_size(v) != 0; i++) tick;
    switch_read[v*NP +: NP] = '0;
    check("drain_empty", sb_size(v), 0);
  endtask

  always @(negedge clk)
    if (rst)
      for (int v = 0; v < NV; v++) begin
        mr = switch_request[v*NP +: NP];
        if (error_o[v]) err_cnt[v]++;
        if (|(mr & switch_read[v*NP +: NP])) begin
          if (sb_size(v) == 0) check("extra_pop", 1, 0);
          else begin
            if (v == 0) me = sb0.pop_front();
            else me = sb1.pop_front();
            check("sb_flit", switch_flit[v*FW +: FW], me[33:0]);
            check("sb_port", mr, me[38:34]);
          end
        end
      end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_ready", link_ready, 0);
    check("rst_req", switch_request, 0);
    check("rst_err", error_o, 0);
    check("rst_flit", switch_flit, 0);
    #10 rst = 1'b1;
    tick;
    check("rel_ready", link_ready, 2'b11);

    // basic packet with stalled reads
    h = fl(HDR, 6'd3, 26'($urandom));
    send(0, h, 5'b00100);
    check("t1_req", switch_request[4:0], 5'b00100);
    check("t1_flit", switch_flit[33:0], h);
    send(0, fl(PAY, 6'($urandom), 26'($urandom)), 5'b00100);
    send(0, fl(LST, 6'($urandom), 26'($urandom)), 5'b00100);
    switch_read[4:0] = 5'b11011;
    repeat (3) begin
      tick;
      check("t1_hold_req", switch_request[4:0], 5'b00100);
      check("t1_hold_flit", switch_flit[33:0], h);
    end
    switch_read = '0;
    check("t1_nopop", sb0.size(), 3);
    drain(0, 5'b00100);
    check("t1_empty_req", switch_request[4:0], 0);

    // full FIFO backpressure
    e0 = err_cnt[0];
    send(0, fl(HDR, 6'd1, 26'($urandom)), 5'b00010);
    repeat (3) send(0, fl(PAY, 6'($urandom), 26'($urandom)), 5'b00010);
    check("t2_full", link_ready[0], 0);
    link_flit = fl(PAY, 6'h2a, 26'h3ffffff);
    link_valid[0] = 1'b1;
    tick;
    link_valid = '0;
    check("t2_still_full", link_ready[0], 0);
    switch_read[4:0] = 5'b00010;
    check("t2_pop_same_cycle", link_ready[0], 0);
    tick;
    switch_read = '0;
    check("t2_ready_back", link_ready[0], 1);
    send(0, fl(LST, 6'($urandom), 26'($urandom)), 5'b00010);
    drain(0, 5'b00010);
    check("t2_no_err", err_cnt[0] - e0, 0);

    // SINGLE followed by a header decoded at once
    s = fl(SGL, 6'd0, 26'($urandom));
    send(0, s, 5'b00001);
    check("t3_req", switch_request[4:0], 5'b00001);
    h = fl(HDR, 6'd3, 26'($urandom));
    send(0, h, 5'b00100);
    check("t3_req_single", switch_request[4:0], 5'b00001);
    switch_read[4:0] = 5'b00001;
    tick;
    switch_read = '0;
    check("t3_hdr_req", switch_request[4:0], 5'b00100);
    check("t3_hdr_flit", switch_flit[33:0], h);
    send(0, fl(PAY, 6'($urandom), 26'($urandom)), 5'b00100);
    send(0, fl(LST, 6'($urandom), 26'($urandom)), 5'b00100);
    drain(0, 5'b00100);

    // out-of-range and zero routes
    e0 = err_cnt[0];
    send(0, fl(HDR, 6'd33, 26'($urandom)), 5'b0);
    check("t4_err", error_o[0], 1);
    check("t4_req", switch_request[4:0], 0);
    send(0, fl(PAY, 6'd3, 26'($urandom)), 5'b0);
    check("t4_err_pay", error_o[0], 0);
    check("t4_req_pay", switch_request[4:0], 0);
    send(0, fl(LST, 6'd3, 26'($urandom)), 5'b0);
    check("t4_err_last", error_o[0], 0);
    check("t4_req_last", switch_request[4:0], 0);
    tick;
    check("t4_err_count", err_cnt[0] - e0, 1);
    send(0, fl(SGL, 6'd5, 26'($urandom)), 5'b0);
    check("t4_zero_err", error_o[0], 1);
    check("t4_zero_req", switch_request[4:0], 0);
    tick;
    check("t4_zero_pulse", error_o[0], 0);
    check("t4_err_count2", err_cnt[0] - e0, 2);
    s = fl(SGL, 6'd4, 26'($urandom));
    send(0, s, 5'b10000);
    check("t4_idle_req", switch_request[4:0], 5'b10000);
    drain(0, 5'b10000);

    // stray payload, then reset mid-packet
    e0 = err_cnt[0];
    send(0, fl(PAY, 6'd1, 26'($urandom)), 5'b0);
    check("t5_err", error_o[0], 1);
    check("t5_req", switch_request[4:0], 0);
    tick;
    check("t5_err_pulse", error_o[0], 0);
    check("t5_err_count", err_cnt[0] - e0, 1);
    send(0, fl(HDR, 6'd1, 26'($urandom)), 5'b00010);
    send(0, fl(PAY, 6'($urandom), 26'($urandom)), 5'b00010);
    check("t5_pre_req", switch_request[4:0], 5'b00010);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_ready", link_ready, 0);
    check("t5_rst_req", switch_request, 0);
    check("t5_rst_err", error_o, 0);
    check("t5_rst_flit", switch_flit, 0);
    sb0.delete();
    sb1.delete();
    #3 rst = 1'b1;
    tick;
    check("t5_rel_ready", link_ready, 2'b11);
    check("t5_rel_req", switch_request, 0);
    s = fl(SGL, 6'd4, 26'($urandom));
    send(0, s, 5'b10000);
    check("t5_fresh_head", switch_flit[33:0], s);
    drain(0, 5'b10000);

    // two VCs: VC0 stalled, VC1 streaming
    e0 = err_cnt[0];
    e1 = err_cnt[1];
    switch_read[9:5] = 5'b10000;
    h = fl(HDR, 6'd1, 26'($urandom));
    send(0, h, 5'b00010);
    send(1, fl(HDR, 6'd4, 26'($urandom)), 5'b10000);
    send(0, fl(PAY, 6'($urandom), 26'($urandom)), 5'b00010);
    send(1, fl(PAY, 6'($urandom), 26'($urandom)), 5'b10000);
    send(0, fl(LST, 6'($urandom), 26'($urandom)), 5'b00010);
    send(1, fl(PAY, 6'($urandom), 26'($urandom)), 5'b10000);
    send(1, fl(PAY, 6'($urandom), 26'($urandom)), 5'b10000);
    send(1, fl(LST, 6'($urandom), 26'($urandom)), 5'b10000);
    check("t6_vc1_ready", link_ready[1], 1);
    tick;
    check("t6_vc1_tput", sb1.size(), 0);
    check("t6_vc0_stall", sb0.size(), 3);
    check("t6_vc0_req", switch_request[4:0], 5'b00010);
    check("t6_vc0_flit", switch_flit[33:0], h);
    switch_read[9:5] = '0;
    drain(0, 5'b00010);
    check("t6_err0", err_cnt[0] - e0, 0);
    check("t6_err1", err_cnt[1] - e1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
